// File: rtl/trace_pkg.sv
// Shared types for the retire-trace capture buffer.
// Define TRACE_TIMESTAMP_EN to add a 32-bit cycle stamp to every trace entry.
package trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_FROZEN  = 2'd3
  } trace_state_e;

  // One retired instruction as the tracer sees it; 135 bits without the stamp.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        rdv;
    logic [4:0]  rd;
    logic [31:0] rd_data;
    logic        pcv;
    logic [31:0] pc_x;
`ifdef TRACE_TIMESTAMP_EN
    logic [31:0] stamp;
`endif
  } trace_entry_t;

  localparam int unsigned TRACE_ENTRY_W = $bits(trace_entry_t);

endpackage

// File: rtl/trace_ram.sv
// Flop-array ring storage: one write port per retire lane, one async read port.
module trace_ram
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned LANES = 1,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic [LANES-1:0]   we_i,
  input  logic [AW-1:0]      waddr_i [LANES],
  input  trace_entry_t       wdata_i [LANES],
  input  logic [AW-1:0]      raddr_i,
  output trace_entry_t       rdata_o
);

  trace_entry_t mem_q [DEPTH];

  // NOTE: storage is not reset; count/pointers gate what is visible, and a
  // reset net on every bit would only cost routing.
  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (we_i[l]) mem_q[waddr_i[l]] <= wdata_i[l];
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/trace_buffer.sv
// Retire-trace capture ring with PC trigger, post-trigger window and drain port.
// Define TRACE_TIMESTAMP_EN to stamp each entry with a free-running cycle count.
module trace_buffer
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned LANES = 1,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [LANES-1:0]       valid,
  input  logic [LANES-1:0][31:0] pc,
  input  logic [LANES-1:0][31:0] inst,
  input  logic [LANES-1:0]       rdv,
  input  logic [LANES-1:0][4:0]  rd,
  input  logic [LANES-1:0][31:0] rd_data,
  input  logic [LANES-1:0]       pcv,
  input  logic [LANES-1:0][31:0] pc_x,
  input  logic                   arm,
  input  logic                   clear,
  input  logic                   stop,
  input  logic                   trig_en,
  input  logic [31:0]            trig_pc,
  input  logic [CW-1:0]          post_len,
  output logic [1:0]             state,
  output logic [CW-1:0]          count,
  output logic                   wrapped,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output trace_entry_t           rd_entry
);

  trace_state_e  state_q;
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q, remain_q;
  logic          wrapped_q;

  logic          capturing, trig_hit, pop, fill_over;
  logic [CW-1:0] n_wr, fill, remain_next;
  logic [LANES-1:0] we;
  logic [AW-1:0] waddr [LANES];
  trace_entry_t  wdata [LANES];

`ifdef TRACE_TIMESTAMP_EN
  logic [31:0] stamp_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stamp_q <= '0;
    else        stamp_q <= stamp_q + 32'd1;
  end
`endif

  // NOTE: every comb output gets a default first so no path infers a latch.
  always_comb begin
    capturing = (state_q == ST_ARMED || state_q == ST_CAPTURE) && !clear;
    trig_hit  = 1'b0;
    n_wr      = '0;
    for (int l = 0; l < LANES; l++) begin
      // NOTE: n_wr is a blocking running total, so each lane sees the
      // number of valid lanes below it; this packs a lone lane 1 into one slot.
      we[l]    = capturing && valid[l];
      waddr[l] = wptr_q + n_wr[AW-1:0];
      if (we[l]) n_wr = n_wr + CW'(1);
      trig_hit = trig_hit | (trig_en && valid[l] && (pc[l] == trig_pc));
      wdata[l].pc      = pc[l];
      wdata[l].inst    = inst[l];
      wdata[l].rdv     = rdv[l];
      wdata[l].rd      = rd[l];
      wdata[l].rd_data = rd_data[l];
      wdata[l].pcv     = pcv[l];
      wdata[l].pc_x    = pc_x[l];
`ifdef TRACE_TIMESTAMP_EN
      wdata[l].stamp   = stamp_q;
`endif
    end
    // fill never exceeds DEPTH+LANES < 2*DEPTH, so its low bits are the overflow.
    fill        = count_q + n_wr;
    fill_over   = fill > CW'(DEPTH);
    remain_next = (n_wr >= remain_q) ? '0 : remain_q - n_wr;
    pop         = (state_q == ST_FROZEN) && (count_q != '0) && rd_ready;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      remain_q  <= '0;
      wrapped_q <= 1'b0;
    end else if (clear) begin
      state_q   <= ST_IDLE;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      remain_q  <= '0;
      wrapped_q <= 1'b0;
    end else begin
      if (n_wr != '0) begin
        wptr_q <= wptr_q + n_wr[AW-1:0];
        if (fill_over) begin
          count_q   <= CW'(DEPTH);
          rptr_q    <= rptr_q + fill[AW-1:0];
          wrapped_q <= 1'b1;
        end else begin
          count_q <= fill;
        end
      end
      case (state_q)
        ST_IDLE: if (arm) state_q <= ST_ARMED;
        ST_ARMED: begin
          if (stop) begin
            state_q <= ST_FROZEN;
          end else if (trig_hit) begin
            remain_q <= post_len;
            state_q  <= (post_len == '0) ? ST_FROZEN : ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          remain_q <= remain_next;
          if (stop || remain_next == '0) state_q <= ST_FROZEN;
        end
        ST_FROZEN: begin
          if (pop) begin
            rptr_q  <= rptr_q + AW'(1);
            count_q <= count_q - CW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  trace_ram #(.DEPTH(DEPTH), .LANES(LANES)) u_ram (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .raddr_i (rptr_q),
    .rdata_o (rd_entry)
  );

  assign state    = state_q;
  assign count    = count_q;
  assign wrapped  = wrapped_q;
  assign rd_valid = (state_q == ST_FROZEN) && (count_q != '0);

endmodule

// File: tb/tb_trace_buffer.sv
// Directed bench for trace_buffer (DEPTH=8, LANES=2; single-lane cases drive lane 0 only).
module tb_trace_buffer;
  import trace_pkg::*;

  localparam int DEPTH = 8;
  localparam int LANES = 2;
  localparam int CW    = 4;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [LANES-1:0]       valid, rdv, pcv;
  logic [LANES-1:0][31:0] pc, inst, rd_data, pc_x;
  logic [LANES-1:0][4:0]  rd;
  logic                   arm, clear, stop, trig_en, rd_ready;
  logic [31:0]            trig_pc;
  logic [CW-1:0]          post_len;
  logic [1:0]             state;
  logic [CW-1:0]          count;
  logic                   wrapped, rd_valid;
  trace_entry_t           rd_entry;

  int vectors = 0;
  int errors  = 0;

  trace_buffer #(.DEPTH(DEPTH), .LANES(LANES)) dut (
    .clk(clk), .reset(reset), .valid(valid), .pc(pc), .inst(inst), .rdv(rdv),
    .rd(rd), .rd_data(rd_data), .pcv(pcv), .pc_x(pc_x), .arm(arm), .clear(clear),
    .stop(stop), .trig_en(trig_en), .trig_pc(trig_pc), .post_len(post_len),
    .state(state), .count(count), .wrapped(wrapped), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_entry(rd_entry)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge, sample point is 1ns after it; pulses and lanes drop.
  task automatic step();
    @(posedge clk);
    #1;
    valid = '0; arm = 1'b0; clear = 1'b0; stop = 1'b0; rd_ready = 1'b0;
  endtask

  task automatic put(input int lane, input logic [31:0] p);
    valid[lane]   = 1'b1;
    pc[lane]      = p;
    inst[lane]    = p ^ 32'h00ab_0013;
    rdv[lane]     = p[2];
    rd[lane]      = p[6:2];
    rd_data[lane] = p + 32'h11;
    pcv[lane]     = p[3];
    pc_x[lane]    = p + 32'h1000;
  endtask

  task automatic drain(input string tag, input logic [31:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      check({tag, "_rdv"}, rd_valid, 1'b1);
      check({tag, "_pc"}, rd_entry.pc, first + 32'(i * 4));
      rd_ready = 1'b1;
      step();
    end
    check({tag, "_cnt0"}, count, 0);
    check({tag, "_rdv0"}, rd_valid, 1'b0);
  endtask

  initial begin
    reset = 1'b0;
    valid = '0; rdv = '0; pcv = '0; pc = '0; inst = '0; rd_data = '0; pc_x = '0; rd = '0;
    arm = 1'b0; clear = 1'b0; stop = 1'b0; trig_en = 1'b0; rd_ready = 1'b0;
    trig_pc = '0; post_len = '0;
    #12;
    check("rst_state", state, 2'd0);
    check("rst_count", count, 0);
    check("rst_wrapped", wrapped, 1'b0);
    check("rst_rd_valid", rd_valid, 1'b0);
    @(negedge clk) reset = 1'b1;
    step();

    // Basic capture of five retires, then stop and drain.
    arm = 1'b1; step();
    check("t1_armed", state, 2'd1);
    for (int i = 0; i < 5; i++) begin put(0, 32'h100 + 32'(i * 4)); step(); end
    check("t1_count", count, 5);
    check("t1_still_armed", state, 2'd1);
    stop = 1'b1; step();
    check("t1_frozen", state, 2'd3);
    check("t1_wrapped", wrapped, 1'b0);
    check("t1_inst", rd_entry.inst, 32'h00ab_0113);
    check("t1_rd_data", rd_entry.rd_data, 32'h111);
    arm = 1'b1; step();
    check("t1_arm_ignored", state, 2'd3);
    rd_ready = 1'b1; step();
    check("t1_pop_count", count, 4);
    check("t1_pop_pc", rd_entry.pc, 32'h104);
    drain("t1", 32'h104, 4);
    clear = 1'b1; step();
    check("t1_clear", state, 2'd0);

    // Overflow: twelve retires into eight slots.
    arm = 1'b1; step();
    for (int i = 0; i < 12; i++) begin put(0, 32'(i * 4)); step(); end
    stop = 1'b1; step();
    check("t2_count", count, 8);
    check("t2_wrapped", wrapped, 1'b1);
    drain("t2", 32'h10, 8);
    clear = 1'b1; step();
    check("t2_clr_wrapped", wrapped, 1'b0);

    // Trigger at 0x200 with a three-entry post window.
    trig_en = 1'b1; trig_pc = 32'h200; post_len = 4'd3;
    arm = 1'b1; step();
    for (int p = 32'h1F8; p <= 32'h220; p += 4) begin
      put(0, 32'(p)); step();
      if (p == 32'h1FC) check("t3_pre_armed", state, 2'd1);
      if (p == 32'h200) check("t3_capture", state, 2'd2);
      if (p == 32'h208) check("t3_still_cap", state, 2'd2);
      if (p == 32'h20C) check("t3_frozen", state, 2'd3);
    end
    check("t3_count", count, 6);
    drain("t3", 32'h1F8, 6);
    trig_en = 1'b0;
    clear = 1'b1; step();

    // Lone lane 1 retires pack into consecutive slots.
    arm = 1'b1; step();
    for (int i = 0; i < 4; i++) begin put(1, 32'h300 + 32'(i * 4)); step(); end
    check("t4_count", count, 4);
    stop = 1'b1; step();
    check("t4_pc_x", rd_entry.pc_x, 32'h1300);
    drain("t4", 32'h300, 4);
    clear = 1'b1; step();

    // Dual-lane capture, trigger on lane 1 with no post window.
    trig_en = 1'b1; trig_pc = 32'h404; post_len = 4'd0;
    arm = 1'b1; step();
    put(0, 32'h3F8); put(1, 32'h3FC); step();
    check("t5_dual_count", count, 2);
    check("t5_armed", state, 2'd1);
    put(0, 32'h400); put(1, 32'h404); step();
    check("t5_frozen", state, 2'd3);
    check("t5_count", count, 4);
    drain("t5", 32'h3F8, 4);
    trig_en = 1'b0;
    clear = 1'b1; step();

    // clear beats arm; stop ignored in IDLE.
    arm = 1'b1; clear = 1'b1; step();
    check("t6_arm_clear", state, 2'd0);
    stop = 1'b1; step();
    check("t6_stop_idle", state, 2'd0);

    // Asynchronous reset in the middle of a capture window.
    trig_en = 1'b1; trig_pc = 32'h500; post_len = 4'd5;
    arm = 1'b1; step();
    put(0, 32'h500); step();
    check("t7_capture", state, 2'd2);
    put(0, 32'h504); step();
    check("t7_count", count, 2);
    reset = 1'b0;
    #1;
    check("t7_rst_state", state, 2'd0);
    check("t7_rst_count", count, 0);
    check("t7_rst_rdv", rd_valid, 1'b0);
    trig_en = 1'b0;
    @(negedge clk) reset = 1'b1;
    step();
    check("t7_post_rst", state, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
